// File: rtl/vga_sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_pkg
// Shared raster timing numbers and helpers for the VGA sync generator and for
// every consumer of the 1-based position bus. The DEF_* values are the single
// source of the 640x480 timing. Sync generator parameters default from them,
// and pixel consumers read the same constants.
// -----------------------------------------------------------------------------
package vga_sync_gen_pkg;

    // Position bus width and the largest value it can carry.
    localparam int POS_W     = 10;
    localparam int POS_LIMIT = (1 << POS_W) - 1;

    // Horizontal timing, in 1-based columns.
    localparam int DEF_H_VISIBLE    = 640;
    localparam int DEF_H_PULSE_HEAD = 657;
    localparam int DEF_H_PULSE_TAIL = 752;
    localparam int DEF_H_MAX        = 800;

    // Vertical timing, in 1-based lines.
    localparam int DEF_V_VISIBLE    = 480;
    localparam int DEF_V_PULSE_HEAD = 491;
    localparam int DEF_V_PULSE_TAIL = 492;
    localparam int DEF_V_MAX        = 525;

    // Inclusive range test on a position value.
    function automatic logic in_range(input logic [POS_W-1:0] pos,
                                      input logic [POS_W-1:0] lo,
                                      input logic [POS_W-1:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_axis.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a 1-based position counter that wraps MAX -> 1, plus the
// registered sync decode for that axis. The sync flop is decoded from the
// next position, so it changes on the same edge as the position it describes.
//
// Ports
//   clk_i     pixel clock
//   rst_ni    asynchronous active-low reset
//   step_i    advance one position this cycle
//   pos_o     current position, 1..MAX (registered)
//   wrap_o    high when this cycle's step takes MAX back to 1 (combinational)
//   sync_n_o  active-low sync: low while the position is inside the pulse
//   vis_d_o   next position is within the visible range (combinational; the
//             parent registers it after combining both axes)
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int MAX        = DEF_H_MAX,
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int PULSE_HEAD = DEF_H_PULSE_HEAD,
    parameter int PULSE_TAIL = DEF_H_PULSE_TAIL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o,
    output logic             sync_n_o,
    output logic             vis_d_o
);

    localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);
    localparam logic [POS_W-1:0] VIS_P  = POS_W'(VISIBLE);
    localparam logic [POS_W-1:0] HEAD_P = POS_W'(PULSE_HEAD);
    localparam logic [POS_W-1:0] TAIL_P = POS_W'(PULSE_TAIL);
    localparam logic [POS_W-1:0] ONE_P  = POS_W'(1);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             sync_n_q, sync_n_d;

    always_comb begin
        pos_d  = pos_q;
        wrap_o = 1'b0;
        if (step_i) begin
            if (pos_q == MAX_P) begin
                pos_d  = ONE_P;
                wrap_o = 1'b1;
            end else begin
                pos_d = pos_q + ONE_P;
            end
        end
        sync_n_d = ~in_range(pos_d, HEAD_P, TAIL_P);
        vis_d_o  = (pos_d <= VIS_P);
    end

    // Reset state is position 1 with the sync decoded for position 1, so the
    // outputs are already consistent on the first cycle after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q    <= ONE_P;
            sync_n_q <= ~in_range(ONE_P, HEAD_P, TAIL_P);
        end else begin
            pos_q    <= pos_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign pos_o    = pos_q;
    assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Raster timing generator. Two cascaded axis counters produce the 1-based
// position bus consumed by the sprite/video blocks and the active-low
// HSync/VSync pins. Every output is a flop. All decodes are taken from the
// next position, so syncs, visibility and the frame strobe line up with the
// position outputs.
//
// Ports
//   i_Clk          pixel clock
//   i_Rst_N        asynchronous active-low reset
//   i_Pix_En       advance enable, one pixel per enabled cycle
//   o_HSync_Pos    current column, 1..H_MAX
//   o_VSync_Pos    current line, 1..V_MAX
//   o_HSync        horizontal sync, active-low
//   o_VSync        vertical sync, active-low
//   o_Visible      column <= H_VISIBLE and line <= V_VISIBLE
//   o_Frame_Start  one-cycle strobe on the step into (1,1)
//   o_Frame_Cnt    frames completed since reset, modulo 256
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_VISIBLE    = DEF_H_VISIBLE,
    parameter int H_PULSE_HEAD = DEF_H_PULSE_HEAD,
    parameter int H_PULSE_TAIL = DEF_H_PULSE_TAIL,
    parameter int H_MAX        = DEF_H_MAX,
    parameter int V_VISIBLE    = DEF_V_VISIBLE,
    parameter int V_PULSE_HEAD = DEF_V_PULSE_HEAD,
    parameter int V_PULSE_TAIL = DEF_V_PULSE_TAIL,
    parameter int V_MAX        = DEF_V_MAX
) (
    input  logic             i_Clk,
    input  logic             i_Rst_N,
    input  logic             i_Pix_En,
    output logic [POS_W-1:0] o_HSync_Pos,
    output logic [POS_W-1:0] o_VSync_Pos,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Visible,
    output logic             o_Frame_Start,
    output logic [7:0]       o_Frame_Cnt
);

    // Positions are 10-bit, and the pulse windows must sit inside each axis.
    if (H_MAX > POS_LIMIT || V_MAX > POS_LIMIT) begin : g_width_check
        $error("vga_sync_gen: H_MAX/V_MAX exceed the 10-bit position range");
    end
    if (H_MAX < 1 || V_MAX < 1 ||
        H_PULSE_HEAD > H_PULSE_TAIL || H_PULSE_TAIL > H_MAX ||
        V_PULSE_HEAD > V_PULSE_TAIL || V_PULSE_TAIL > V_MAX) begin : g_order_check
        $error("vga_sync_gen: inconsistent timing parameters");
    end

    logic h_wrap, v_wrap;
    logic h_vis_d, v_vis_d;
    logic v_step;

    logic       visible_q, visible_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    vga_axis_counter #(
        .MAX        (H_MAX),
        .VISIBLE    (H_VISIBLE),
        .PULSE_HEAD (H_PULSE_HEAD),
        .PULSE_TAIL (H_PULSE_TAIL)
    ) u_h_axis (
        .clk_i    (i_Clk),
        .rst_ni   (i_Rst_N),
        .step_i   (i_Pix_En),
        .pos_o    (o_HSync_Pos),
        .wrap_o   (h_wrap),
        .sync_n_o (o_HSync),
        .vis_d_o  (h_vis_d)
    );

    // A line is a whole number of columns, so VSync changes only on a column
    // wrap. It falls entering (1, V_PULSE_HEAD) and rises leaving
    // (H_MAX, V_PULSE_TAIL).
    assign v_step = h_wrap & i_Pix_En;

    vga_axis_counter #(
        .MAX        (V_MAX),
        .VISIBLE    (V_VISIBLE),
        .PULSE_HEAD (V_PULSE_HEAD),
        .PULSE_TAIL (V_PULSE_TAIL)
    ) u_v_axis (
        .clk_i    (i_Clk),
        .rst_ni   (i_Rst_N),
        .step_i   (v_step),
        .pos_o    (o_VSync_Pos),
        .wrap_o   (v_wrap),
        .sync_n_o (o_VSync),
        .vis_d_o  (v_vis_d)
    );

    // v_wrap already includes the column wrap and the enable. The strobe is
    // therefore zero on any cycle with i_Pix_En low.
    always_comb begin
        visible_d     = h_vis_d & v_vis_d;
        frame_start_d = v_wrap;
        frame_cnt_d   = frame_cnt_q;
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Position (1,1) is always visible, so visibility resets high. No strobe
    // is issued for the frame that starts at reset release.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            visible_q     <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            visible_q     <= visible_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign o_Visible     = visible_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Frame_Cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen. One instance uses the default 640x480
// timing for the line sweep, enable hold and mid-frame reset. A second
// instance uses a small 8x6 raster for whole-frame, random-enable and
// frame-counter wrap behaviour. The small raster has visible 5x3, an HSync
// pulse on columns 6..7 and a VSync pulse on lines 4..5.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- default-timing instance ----------------
    logic       rst_n_d, en_d;
    logic [9:0] d_hpos, d_vpos;
    logic       d_hs, d_vs, d_vis, d_fs;
    logic [7:0] d_fc;

    vga_sync_gen dut_def (
        .i_Clk         (clk),
        .i_Rst_N       (rst_n_d),
        .i_Pix_En      (en_d),
        .o_HSync_Pos   (d_hpos),
        .o_VSync_Pos   (d_vpos),
        .o_HSync       (d_hs),
        .o_VSync       (d_vs),
        .o_Visible     (d_vis),
        .o_Frame_Start (d_fs),
        .o_Frame_Cnt   (d_fc)
    );

    // ---------------- small-raster instance ----------------
    localparam int SH_VIS = 5, SH_HEAD = 6, SH_TAIL = 7, SH_MAX = 8;
    localparam int SV_VIS = 3, SV_HEAD = 4, SV_TAIL = 5, SV_MAX = 6;

    logic       rst_n_s, en_s;
    logic [9:0] s_hpos, s_vpos;
    logic       s_hs, s_vs, s_vis, s_fs;
    logic [7:0] s_fc;

    vga_sync_gen #(
        .H_VISIBLE (SH_VIS), .H_PULSE_HEAD (SH_HEAD), .H_PULSE_TAIL (SH_TAIL), .H_MAX (SH_MAX),
        .V_VISIBLE (SV_VIS), .V_PULSE_HEAD (SV_HEAD), .V_PULSE_TAIL (SV_TAIL), .V_MAX (SV_MAX)
    ) dut_sm (
        .i_Clk         (clk),
        .i_Rst_N       (rst_n_s),
        .i_Pix_En      (en_s),
        .o_HSync_Pos   (s_hpos),
        .o_VSync_Pos   (s_vpos),
        .o_HSync       (s_hs),
        .o_VSync       (s_vs),
        .o_Visible     (s_vis),
        .o_Frame_Start (s_fs),
        .o_Frame_Cnt   (s_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model of the small raster.
    int   mh, mv, mfc, mwraps;
    int   sm_err, en_cnt, last_fs_en, gap_err, fs_seen, vs_low_cnt;
    int   vfall_h, vfall_v, vlast_h, vlast_v, prev_h, prev_v;
    logic prev_vs;
    logic vis_a, vis_b, vis_c, vis_d;
    logic zwrap_seen, zwrap_fs;
    logic [7:0] zwrap_fc;

    task automatic sm_cycle(input logic en);
        logic wrapped;
        logic e_hs, e_vs, e_vis;
        wrapped = 1'b0;
        en_s = en;
        @(negedge clk);
        prev_h = mh;
        prev_v = mv;
        if (en) begin
            en_cnt++;
            if (mh == SH_MAX) begin
                mh = 1;
                if (mv == SV_MAX) begin
                    mv = 1;
                    wrapped = 1'b1;
                    mfc = (mfc + 1) % 256;
                    mwraps++;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        e_hs  = !(mh >= SH_HEAD && mh <= SH_TAIL);
        e_vs  = !(mv >= SV_HEAD && mv <= SV_TAIL);
        e_vis = (mh <= SH_VIS) && (mv <= SV_VIS);
        if (s_hpos !== 10'(mh) || s_vpos !== 10'(mv) || s_hs !== e_hs || s_vs !== e_vs ||
            s_vis !== e_vis || s_fs !== wrapped || s_fc !== 8'(mfc))
            sm_err++;
        if (s_fs === 1'b1) begin
            fs_seen++;
            if (last_fs_en != 0 && (en_cnt - last_fs_en) != SH_MAX * SV_MAX) gap_err++;
            last_fs_en = en_cnt;
        end
        if (s_vs === 1'b0) vs_low_cnt++;
        if (prev_vs === 1'b1 && s_vs === 1'b0) begin vfall_h = mh; vfall_v = mv; end
        if (prev_vs === 1'b0 && s_vs === 1'b1) begin vlast_h = prev_h; vlast_v = prev_v; end
        prev_vs = s_vs;
        if (mh == 5 && mv == 3) vis_a = s_vis;
        if (mh == 6 && mv == 3) vis_b = s_vis;
        if (mh == 5 && mv == 4) vis_c = s_vis;
        if (mh == 8 && mv == 6) vis_d = s_vis;
        if (wrapped && mfc == 0) begin
            zwrap_seen = 1'b1;
            zwrap_fc   = s_fc;
            zwrap_fs   = s_fs;
        end
    endtask

    int   hs_low, hs_first, hs_last, pos_err, line_at_799;
    logic hs_exp;

    initial begin
        rst_n_d = 1'b0; en_d = 1'b0;
        rst_n_s = 1'b0; en_s = 1'b0;
        mh = 1; mv = 1; mfc = 0; mwraps = 0;
        sm_err = 0; en_cnt = 0; last_fs_en = 0; gap_err = 0; fs_seen = 0; vs_low_cnt = 0;
        vfall_h = 0; vfall_v = 0; vlast_h = 0; vlast_v = 0; prev_h = 1; prev_v = 1;
        prev_vs = 1'b1;
        vis_a = 1'bx; vis_b = 1'bx; vis_c = 1'bx; vis_d = 1'bx;
        zwrap_seen = 1'b0; zwrap_fs = 1'b0; zwrap_fc = 8'hxx;
        hs_low = 0; hs_first = 0; hs_last = 0; pos_err = 0; line_at_799 = 0;

        // Reset state while held in reset with the clock running.
        repeat (3) @(negedge clk);
        chk("rst_hpos", d_hpos, 1);
        chk("rst_vpos", d_vpos, 1);
        chk("rst_hsync", d_hs, 1);
        chk("rst_vsync", d_vs, 1);
        chk("rst_visible", d_vis, 1);
        chk("rst_fstart", d_fs, 0);
        chk("rst_fcnt", d_fc, 0);
        chk("rst_sm_vsync", s_vs, 1);

        // Default timing: 800 enabled cycles sweep one full line.
        rst_n_d = 1'b1; en_d = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (d_hpos !== 10'((k % 800) + 1)) pos_err++;
            if (k == 799) line_at_799 = d_vpos;
            hs_exp = !(d_hpos >= 657 && d_hpos <= 752);
            if (d_hs !== hs_exp) pos_err++;
            if (d_hs === 1'b0) begin
                if (hs_low == 0) hs_first = d_hpos;
                hs_last = d_hpos;
                hs_low++;
            end
        end
        chk("sweep_pos_hsync_err", pos_err, 0);
        chk("line_at_col800", line_at_799, 1);
        chk("line_after_wrap", d_vpos, 2);
        chk("col_after_wrap", d_hpos, 1);
        chk("hsync_low_cycles", hs_low, 96);
        chk("hsync_first_col", hs_first, 657);
        chk("hsync_last_col", hs_last, 752);
        chk("no_strobe_line_wrap", d_fs, 0);

        // Enable low: everything holds.
        en_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_hpos", d_hpos, 1);
        chk("hold_vpos", d_vpos, 2);
        chk("hold_visible", d_vis, 1);

        // Advance to (300,2), then assert reset away from the clock edge.
        en_d = 1'b1;
        repeat (299) @(negedge clk);
        chk("pre_reset_hpos", d_hpos, 300);
        #2 rst_n_d = 1'b0;
        #1;
        chk("async_rst_hpos", d_hpos, 1);
        chk("async_rst_vpos", d_vpos, 1);
        chk("async_rst_hsync", d_hs, 1);
        @(negedge clk);
        rst_n_d = 1'b1;
        @(negedge clk);
        chk("post_rst_hpos", d_hpos, 2);
        chk("post_rst_vpos", d_vpos, 1);
        chk("post_rst_fstart", d_fs, 0);
        en_d = 1'b0;

        // Small raster: one full frame with enable high.
        @(negedge clk);
        rst_n_s = 1'b1;
        for (int k = 0; k < SH_MAX * SV_MAX; k++) sm_cycle(1'b1);
        chk("frame_model_err", sm_err, 0);
        chk("frame_strobes", fs_seen, 1);
        chk("frame_cnt_1", s_fc, 1);
        chk("frame_end_hpos", s_hpos, 1);
        chk("frame_end_vpos", s_vpos, 1);
        chk("vsync_low_cycles", vs_low_cnt, 2 * SH_MAX);
        chk("vsync_fall_col", vfall_h, 1);
        chk("vsync_fall_line", vfall_v, SV_HEAD);
        chk("vsync_last_low_col", vlast_h, SH_MAX);
        chk("vsync_last_low_line", vlast_v, SV_TAIL);
        chk("vis_5_3", vis_a, 1);
        chk("vis_6_3", vis_b, 0);
        chk("vis_5_4", vis_c, 0);
        chk("vis_8_6", vis_d, 0);

        // Pseudo-random enable across several wraps.
        fs_seen = 0; mwraps = 0;
        for (int k = 0; k < 400; k++) sm_cycle(1'($urandom_range(0, 1)));
        chk("rand_model_err", sm_err, 0);
        chk("rand_strobe_gap_err", gap_err, 0);
        chk("rand_strobe_count", fs_seen, mwraps);
        chk("rand_wrapped_some", (mwraps > 0), 1);

        // Run until the frame counter wraps 255 -> 0.
        for (int k = 0; k < 260 * SH_MAX * SV_MAX && !zwrap_seen; k++) sm_cycle(1'b1);
        chk("fcnt_wrap_reached", zwrap_seen, 1);
        chk("fcnt_wrap_value", zwrap_fc, 0);
        chk("fcnt_wrap_strobe", zwrap_fs, 1);
        chk("wrap_model_err", sm_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator driving the shared 1-based position bus (`o_HSync_Pos`/`o_VSync_Pos`) consumed by every sprite/video block (ball, paddles, score), plus the active-low HSync/VSync pins of the VGA connector. It is the producer end of the position interface: pixel consumers compare against these counters and must see sync edges exactly at the macro positions defined in `VgaTiming.v`. Sits directly under the top level, one instance per design.

## Interface
- `H_VISIBLE`, default 640: last visible column.
- `H_PULSE_HEAD`, default 657: first column with HSync low.
- `H_PULSE_TAIL`, default 752: last column with HSync low.
- `H_MAX`, default 800: last column; wraps to 1.
- `V_VISIBLE`, default 480: last visible line.
- `V_PULSE_HEAD`, default 491: first line with VSync low.
- `V_PULSE_TAIL`, default 492: last line with VSync low.
- `V_MAX`, default 525: last line; wraps to 1.
- `i_Clk`  in  1  pixel-domain clock (one clock; everything here is on it).
- `i_Rst_N`  in  1  reset, asynchronous assert, active-low.
- `i_Pix_En`  in  1  advance enable; counters step one pixel per cycle where high.
- `o_HSync_Pos`  out  10  current column, 1..H_MAX.
- `o_VSync_Pos`  out  10  current line, 1..V_MAX.
- `o_HSync`  out  1  horizontal sync, active-low.
- `o_VSync`  out  1  vertical sync, active-low.
- `o_Visible`  out  1  high when column ≤ H_VISIBLE and line ≤ V_VISIBLE.
- `o_Frame_Start`  out  1  one-cycle strobe on entry to (1,1).
- `o_Frame_Cnt`  out  8  frames completed since reset, wraps 255→0.

## Operation
- Column counter: on `i_Pix_En`, H_MAX→1, else +1.
- Line counter: advances only on column wrap; V_MAX→1, else +1.
- `o_HSync` low iff column in [H_PULSE_HEAD, H_PULSE_TAIL].
- `o_VSync` low for whole lines in [V_PULSE_HEAD, V_PULSE_TAIL]: falls with position (1, V_PULSE_HEAD), rises after (H_MAX, V_PULSE_TAIL). Consumers rely on exactly these two points.
- `o_Visible` is the AND of both range checks.
- Wrap (H_MAX, V_MAX)→(1,1): `o_Frame_Cnt` +1 (mod 256), `o_Frame_Start` high.
- `i_Pix_En` low: all positions, syncs, `o_Visible`, `o_Frame_Cnt` hold; `o_Frame_Start` drops to 0.
- No other states; the block is two cascaded counters plus registered decode.

## Timing
- Every output is a flop. Syncs, `o_Visible` and `o_Frame_Start` are decoded from next-position so they are cycle-aligned with the position outputs they describe (zero skew, zero latency relative to position).
- Reset values: positions 1/1, `o_HSync`=1, `o_VSync`=1, `o_Visible`=1, `o_Frame_Start`=0, `o_Frame_Cnt`=0. Exiting reset gives no frame strobe for the first frame.
- Reset mid-frame: all outputs return to reset values asynchronously; first enabled cycle after release shows (2,1).
- Frame period with `i_Pix_En` tied high: H_MAX×V_MAX = 420000 cycles; `o_Frame_Start` period identical.
- Positions never show 0 or values above the MAX parameters, including at reset release.
- Width rule: positions are 10-bit; parameters above 1023 are illegal (elaboration check).

## Structure
- Default timing numbers stay as macros in `VgaTiming.v` (`H_MAX`, `V_PULSE_HEAD`, `V_PULSE_TAIL`, visible-area sizes); parameters default from them so consumers and generator share one source.
- Natural sub-module: `vga_axis_counter` (parameters MAX, VISIBLE, PULSE_HEAD, PULSE_TAIL; inputs step enable; outputs position, wrap, in-pulse, in-visible). Instantiated twice: horizontal stepped by `i_Pix_En`, vertical by horizontal wrap AND `i_Pix_En`.

## Test plan
- Reset then 800 enabled cycles -> column 1..800 then 1, line 1→2 on cycle 800; `o_HSync` low exactly for columns 657..752 (96 cycles).
- Run one full frame -> `o_VSync` low from (1,491) through (800,492), 1600 cycles; `o_Frame_Start` single pulse at (1,1) after 420000 cycles; `o_Frame_Cnt`=1.
- `o_Visible` sampled at (640,480)=1, (641,480)=0, (640,481)=0, (800,525)=0.
- Toggle `i_Pix_En` 50% pseudo-random across the wrap -> positions hold on low cycles; `o_Frame_Start` high exactly one cycle; frame takes 420000 enabled cycles.
- Assert `i_Rst_N` low at (300,200) mid-cycle -> outputs immediately at reset values; after release first step gives (2,1).
- Run 256 frames (or force via short parameters H_MAX=8, V_MAX=4) -> `o_Frame_Cnt` wraps 255→0 with strobe still issued.
